// File: rtl/temporal_pkg.sv
// Shared types for the temporal version buffer: slot layout, pointer/count widths, wrap increment.
// Default geometry lives here; the top-level parameters default to these values.
// Pure package, no timing or flow control.
package temporal_pkg;
    localparam int TP_DATA_WIDTH    = 32;
    localparam int TP_VERSION_WIDTH = 4;
    localparam int TP_VERSION_NUM   = 4;
    localparam int PTR_W            = $clog2(TP_VERSION_NUM);
    localparam int CNT_W            = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [TP_VERSION_WIDTH-1:0] version;
        logic [TP_DATA_WIDTH-1:0]    data;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(TP_VERSION_NUM - 1)) ? '0 : p + ptr_t'(1);
    endfunction
endpackage

// File: rtl/temporal_lookup.sv
// Newest-version-less-or-equal select over the circular slot store for one read port.
// Purely combinational; the caller registers the result.
// No flow control: evaluated every cycle from the current (pre-update) store.
module temporal_lookup
    import temporal_pkg::*;
(
    input  logic [TP_VERSION_NUM*SLOT_W-1:0] slots_i,
    input  logic [PTR_W-1:0]                 tail_i,
    input  logic [CNT_W-1:0]                 count_i,
    input  logic [TP_VERSION_WIDTH-1:0]      version_i,
    output logic [TP_DATA_WIDTH-1:0]         data_o,
    output logic                             hit_o
);
    ptr_t  idx;
    slot_t s;

    // Walk oldest to newest; stored versions ascend, so the last qualifying slot wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        s      = '0;
        for (int k = 0; k < TP_VERSION_NUM; k++) begin
            idx = tail_i + ptr_t'(k);
            s   = slots_i[idx*SLOT_W +: SLOT_W];
            if ((cnt_t'(k) < count_i) && (s.version <= version_i)) begin
                hit_o  = 1'b1;
                data_o = s.data;
            end
        end
    end
endmodule

// File: rtl/temporal_version_buffer.sv
// Version-tagged circular history buffer with DATA_NUM newest-<=-version read ports and in-order retire.
// Reads return one cycle after request and see state before same-cycle write/retire.
// wrReady = !full from registered count; with TEMPORAL_OVERWRITE_EN wrReady is 1 and full writes evict the oldest.
module temporal_version_buffer
    import temporal_pkg::*;
#(
    parameter int DATA_WIDTH    = TP_DATA_WIDTH,
    parameter int DATA_NUM      = 8,
    parameter int VERSION_WIDTH = TP_VERSION_WIDTH,
    parameter int VERSION_NUM   = TP_VERSION_NUM
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic                            wrValid,
    output logic                            wrReady,
    input  logic [VERSION_WIDTH-1:0]        wrVersion,
    input  logic [DATA_WIDTH-1:0]           wrData,
    output logic                            wrErr,
    input  logic                            retireValid,
    input  logic [VERSION_WIDTH-1:0]        retireVersion,
    input  logic [DATA_NUM-1:0]             rdValid,
    input  logic [VERSION_WIDTH*DATA_NUM-1:0] readVersions,
    output logic [DATA_WIDTH*DATA_NUM-1:0]  dataOuts,
    output logic [DATA_NUM-1:0]             rdHit,
    output logic [DATA_NUM-1:0]             rdDone,
    output logic [$clog2(VERSION_NUM):0]    count,
    output logic                            full,
    output logic                            empty
);
    slot_t slot_q [TP_VERSION_NUM];
    ptr_t  head_q, head_d, tail_q, tail_d, newest_idx;
    cnt_t  count_q, count_d;

    logic                          wr_err_q;
    logic [DATA_NUM-1:0]           rd_hit_q, rd_done_q;
    logic [DATA_WIDTH*DATA_NUM-1:0] data_outs_q;

    logic full_c, wr_rdy, wr_fire, wr_mono, wr_acc, wr_drop, wr_ovw, ret_pop;

    logic [TP_VERSION_NUM*SLOT_W-1:0] slots_flat;
    logic [DATA_WIDTH-1:0]            lk_data [DATA_NUM];
    logic [DATA_NUM-1:0]              lk_hit;

    assign full_c     = (count_q == cnt_t'(VERSION_NUM));
    assign newest_idx = head_q - ptr_t'(1);

`ifdef TEMPORAL_OVERWRITE_EN
    assign wr_rdy = 1'b1;
`else
    assign wr_rdy = !full_c;
`endif

    always_comb begin
        wr_fire = wrValid && wr_rdy;
        wr_mono = (count_q == '0) || (wrVersion > slot_q[newest_idx].version);
        wr_acc  = wr_fire && wr_mono;
        wr_drop = wr_fire && !wr_mono;
        // Eviction only reachable when overwrite mode lets a write through while full.
        wr_ovw  = wr_acc && full_c;
        ret_pop = retireValid && (count_q > cnt_t'(1)) &&
                  (slot_q[tail_q].version < retireVersion) && !wr_ovw;

        head_d  = wr_acc ? ptr_inc(head_q) : head_q;
        tail_d  = (ret_pop || wr_ovw) ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        if (wr_acc && !wr_ovw) count_d = count_d + cnt_t'(1);
        if (ret_pop)           count_d = count_d - cnt_t'(1);
    end

    for (genvar k = 0; k < TP_VERSION_NUM; k++) begin : g_flat
        assign slots_flat[k*SLOT_W +: SLOT_W] = slot_q[k];
    end

    for (genvar g = 0; g < DATA_NUM; g++) begin : g_port
        temporal_lookup u_lookup (
            .slots_i   (slots_flat),
            .tail_i    (tail_q),
            .count_i   (count_q),
            .version_i (readVersions[g*VERSION_WIDTH +: VERSION_WIDTH]),
            .data_o    (lk_data[g]),
            .hit_o     (lk_hit[g])
        );
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            wr_err_q    <= 1'b0;
            rd_hit_q    <= '0;
            rd_done_q   <= '0;
            data_outs_q <= '0;
            for (int k = 0; k < TP_VERSION_NUM; k++) slot_q[k] <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_err_q  <= wr_drop;
            rd_done_q <= rdValid;
            if (wr_acc) slot_q[head_q] <= '{version: wrVersion, data: wrData};
            for (int i = 0; i < DATA_NUM; i++) begin
                if (rdValid[i]) begin
                    rd_hit_q[i]                            <= lk_hit[i];
                    data_outs_q[i*DATA_WIDTH +: DATA_WIDTH] <= lk_data[i];
                end
            end
        end
    end

    assign wrReady  = wr_rdy;
    assign wrErr    = wr_err_q;
    assign rdHit    = rd_hit_q;
    assign rdDone   = rd_done_q;
    assign dataOuts = data_outs_q;
    assign count    = count_q;
    assign full     = full_c;
    assign empty    = (count_q == '0);
endmodule

// File: tb/tb_temporal_version_buffer.sv
// Self-checking bench for temporal_version_buffer: directed table/sequences plus randomized traffic
// against a queue-based reference model of the version history.
module tb_temporal_version_buffer;
    localparam int DW = 32, DN = 8, VW = 4, VN = 4, CW = $clog2(VN) + 1;
`ifdef TEMPORAL_OVERWRITE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstN;
    logic wrValid, wrReady, wrErr, retireValid, full, empty;
    logic [VW-1:0] wrVersion, retireVersion;
    logic [DW-1:0] wrData;
    logic [DN-1:0] rdValid, rdHit, rdDone;
    logic [VW*DN-1:0] readVersions;
    logic [DW*DN-1:0] dataOuts;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    temporal_version_buffer dut (
        .clk(clk), .rstN(rstN),
        .wrValid(wrValid), .wrReady(wrReady), .wrVersion(wrVersion), .wrData(wrData), .wrErr(wrErr),
        .retireValid(retireValid), .retireVersion(retireVersion),
        .rdValid(rdValid), .readVersions(readVersions), .dataOuts(dataOuts),
        .rdHit(rdHit), .rdDone(rdDone), .count(count), .full(full), .empty(empty)
    );

    int tests = 0, fails = 0;

    typedef struct { logic [VW-1:0] ver; logic [DW-1:0] dat; } ent_t;
    ent_t mq[$];
    logic [DW-1:0] e_dat [DN];
    bit e_hit [DN];
    bit e_done [DN];
    bit e_err;

    typedef struct { logic [VW-1:0] req; bit hit; logic [DW-1:0] dat; } vec_t;
    vec_t tbl [6];

    localparam logic [DW-1:0] DA = 32'hAAAA_0001, DB = 32'hBBBB_0003, DC = 32'hCCCC_0005;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void m_read(input logic [VW-1:0] r, output bit h, output logic [DW-1:0] d);
        logic [VW-1:0] best;
        h = 1'b0; d = '0; best = '0;
        foreach (mq[k]) begin
            if (mq[k].ver <= r && (!h || mq[k].ver > best)) begin
                h = 1'b1; best = mq[k].ver; d = mq[k].dat;
            end
        end
    endfunction

    task automatic check_all();
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == VN));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("wrReady", 64'(wrReady), 64'(OVR || mq.size() < VN));
        chk("wrErr", 64'(wrErr), 64'(e_err));
        for (int i = 0; i < DN; i++) begin
            chk($sformatf("rdHit[%0d]", i), 64'(rdHit[i]), 64'(e_hit[i]));
            chk($sformatf("dataOuts[%0d]", i), 64'(dataOuts[i*DW +: DW]), 64'(e_dat[i]));
            chk($sformatf("rdDone[%0d]", i), 64'(rdDone[i]), 64'(e_done[i]));
        end
    endtask

    // Inputs are stable when called; predicts from pre-edge model state, advances the model, checks at negedge.
    task automatic cycle();
        bit h, fire, mono, ret, ovw;
        logic [DW-1:0] d;
        for (int i = 0; i < DN; i++) begin
            if (rdValid[i]) begin
                m_read(readVersions[i*VW +: VW], h, d);
                e_hit[i] = h; e_dat[i] = d;
            end
            e_done[i] = rdValid[i];
        end
        fire  = wrValid && (OVR || mq.size() < VN);
        mono  = (mq.size() == 0) || (wrVersion > mq[$].ver);
        ovw   = fire && mono && (mq.size() == VN);
        ret   = retireValid && mq.size() > 1 && mq[0].ver < retireVersion && !ovw;
        e_err = fire && !mono;
        @(posedge clk);
        if (fire && mono) begin
            if (ovw) void'(mq.pop_front());
            mq.push_back('{wrVersion, wrData});
        end
        if (ret) void'(mq.pop_front());
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        wrValid = 0; wrVersion = '0; wrData = '0; retireValid = 0; retireVersion = '0;
        rdValid = '0; readVersions = '0;
    endtask

    task automatic model_clear();
        mq.delete();
        e_err = 0;
        for (int i = 0; i < DN; i++) begin e_hit[i] = 0; e_dat[i] = '0; e_done[i] = 0; end
    endtask

    task automatic do_reset();
        idle();
        rstN = 1'b0;
        #1;
        model_clear();
        @(negedge clk);
        rstN = 1'b1;
        check_all();
    endtask

    task automatic wr(input logic [VW-1:0] v, input logic [DW-1:0] d);
        wrValid = 1; wrVersion = v; wrData = d;
        cycle();
        wrValid = 0;
    endtask

    initial begin
        logic [VW-1:0] last;
        idle();
        rstN = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_wrReady", 64'(wrReady), 64'd1);
        chk("rst_wrErr", 64'(wrErr), 64'd0);
        chk("rst_rdHit", 64'(rdHit), 64'd0);
        chk("rst_rdDone", 64'(rdDone), 64'd0);
        chk("rst_dataOuts", 64'(|dataOuts), 64'd0);
        do_reset();

        // Basic lookup table.
        tbl[0] = '{4'd0, 1'b0, 32'd0};
        tbl[1] = '{4'd1, 1'b1, DA};
        tbl[2] = '{4'd2, 1'b1, DA};
        tbl[3] = '{4'd4, 1'b1, DB};
        tbl[4] = '{4'd5, 1'b1, DC};
        tbl[5] = '{4'd9, 1'b1, DC};
        wr(4'd1, DA); wr(4'd3, DB); wr(4'd5, DC);
        for (int i = 0; i < 6; i++) begin
            rdValid[i] = 1'b1;
            readVersions[i*VW +: VW] = tbl[i].req;
        end
        cycle();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("tbl_hit[%0d]", i), 64'(rdHit[i]), 64'(tbl[i].hit));
            chk($sformatf("tbl_dat[%0d]", i), 64'(dataOuts[i*DW +: DW]), 64'(tbl[i].dat));
        end
        idle();

        // Non-monotonic writes.
        wr(4'd5, 32'hDEAD_0005);
        chk("nm5_err", 64'(wrErr), 64'd1);
        chk("nm5_count", 64'(count), 64'd3);
        cycle();
        chk("nm_err_pulse", 64'(wrErr), 64'd0);
        wr(4'd4, 32'hDEAD_0004);
        chk("nm4_err", 64'(wrErr), 64'd1);
        chk("nm4_count", 64'(count), 64'd3);
        cycle();
        chk("nm4_err_clr", 64'(wrErr), 64'd0);

        // Reset mid-stream (asynchronous assertion).
        do_reset();
        wr(4'd2, 32'h2); wr(4'd4, 32'h4); wr(4'd6, 32'h6);
        rdValid = '1; readVersions = {DN{4'd7}};
        cycle();
        chk("pre_rst_hit", 64'(rdHit), 64'(8'hFF));
        idle();
        #2 rstN = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_rdHit", 64'(rdHit), 64'd0);
        chk("arst_dataOuts", 64'(|dataOuts), 64'd0);
        model_clear();
        @(negedge clk);
        rstN = 1'b1;
        check_all();

`ifndef TEMPORAL_OVERWRITE_EN
        wr(4'd1, 32'h11); wr(4'd2, 32'h22); wr(4'd3, 32'h33); wr(4'd4, 32'h44);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_wrReady", 64'(wrReady), 64'd0);
        retireValid = 1; retireVersion = 4'd3;
        wrValid = 1; wrVersion = 4'd9; wrData = 32'h99;
        chk("ret_wrReady_same", 64'(wrReady), 64'd0);
        cycle();
        wrValid = 0;
        chk("ret1_count", 64'(count), 64'd3);
        chk("ret1_wrReady", 64'(wrReady), 64'd1);
        cycle();
        chk("ret2_count", 64'(count), 64'd2);
        cycle();
        chk("ret3_count", 64'(count), 64'd2);
        idle();
`else
        wr(4'd1, 32'h11); wr(4'd2, 32'h22); wr(4'd3, 32'h33); wr(4'd4, 32'h44); wr(4'd5, 32'h55);
        chk("ovw_count", 64'(count), 64'd4);
        rdValid = 8'b0000_0011;
        readVersions[0 +: VW] = 4'd1;
        readVersions[VW +: VW] = 4'd2;
        cycle();
        chk("ovw_v1_hit", 64'(rdHit[0]), 64'd0);
        chk("ovw_v2_hit", 64'(rdHit[1]), 64'd1);
        chk("ovw_v2_dat", 64'(dataOuts[DW +: DW]), 64'h22);
        idle();
`endif

        // No write-to-read bypass.
        do_reset();
        rdValid[0] = 1; readVersions[0 +: VW] = 4'd7;
        wrValid = 1; wrVersion = 4'd7; wrData = 32'h7777_0007;
        cycle();
        chk("byp_same_hit", 64'(rdHit[0]), 64'd0);
        wrValid = 0;
        cycle();
        chk("byp_next_hit", 64'(rdHit[0]), 64'd1);
        chk("byp_next_dat", 64'(dataOuts[0 +: DW]), 64'h7777_0007);
        idle();

        // Randomized traffic against the model.
        for (int s = 0; s < 6; s++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                last = (mq.size() > 0) ? mq[$].ver : 4'd0;
                wrValid = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0) wrVersion = VW'($urandom_range(0, 15));
                else wrVersion = (last > 4'd13) ? 4'd15 : last + VW'($urandom_range(1, 2));
                wrData = $urandom;
                retireValid = ($urandom_range(0, 2) == 0);
                retireVersion = VW'($urandom_range(0, 15));
                rdValid = DN'($urandom);
                readVersions = VW*DN'($urandom);
                cycle();
            end
            idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
